// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, funct codes,
// ALU and next-PC select codes, FSM states and the decode record.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        logic [3:0]   sel_alu;
        logic         imm_to_alu;
        logic         extop;
        logic         rd;
        logic         lui;
    } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: op/funct to decode record plus a legal bit.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] order_func,
    output decode_t    dec,
    output logic       legal
);

    always_comb begin
        dec         = '0;
        dec.cls     = CL_ALU;
        dec.sel_alu = ALU_ADD;
        legal       = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec.rd = 1'b1;
                case (order_func)
                    FN_ADDU: dec.sel_alu = ALU_ADD;
                    FN_SUBU: dec.sel_alu = ALU_SUB;
                    FN_AND:  dec.sel_alu = ALU_AND;
                    FN_OR:   dec.sel_alu = ALU_OR;
                    FN_SLT:  dec.sel_alu = ALU_SLT;
                    FN_JR: begin
                        dec.cls = CL_JR;
                        dec.rd  = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                dec.imm_to_alu = 1'b1;
                dec.extop      = 1'b1;
            end
            OP_ORI: begin
                dec.imm_to_alu = 1'b1;
                dec.sel_alu    = ALU_OR;
            end
            OP_LUI: begin
                dec.imm_to_alu = 1'b1;
                dec.lui        = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec.cls        = (op == OP_LW) ? CL_LW : CL_SW;
                dec.imm_to_alu = 1'b1;
                dec.extop      = 1'b1;
            end
            // Branch offset is sign-extended; the ALU compares rs against rt.
            OP_BEQ: begin
                dec.cls     = CL_BEQ;
                dec.sel_alu = ALU_SUB;
                dec.extop   = 1'b1;
            end
            OP_J:    dec.cls = CL_J;
            OP_JAL:  dec.cls = CL_JAL;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: walks each instruction through IF/ID/EX/MEM/WB and drives
// the datapath strobes and selects; HALT is entered on illegal encodings or RAM timeout.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] order_func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PC_write,
    output logic       IR_write,
    output logic [1:0] pc_src,
    output logic       GPR_write,
    output logic       rd,
    output logic       jal,
    output logic       imm_to_ALU,
    output logic       Extop,
    output logic       lui,
    output logic [3:0] sel_ALU,
    output logic       RAM_write,
    output logic       RAM_read,
    output logic       RAM_to_GPR,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam int unsigned CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    state_t        state, next_state;
    logic [5:0]    op_q, funct_q;
    logic [5:0]    dec_op, dec_funct;
    decode_t       dec;
    logic          legal;
    logic [CW-1:0] wait_cnt;
    logic          mem_expired;
    logic          illegal_q, timeout_q;

    // ID decodes the live IR fields; every later state uses the copy latched in ID.
    assign dec_op    = (state == S_ID) ? op : op_q;
    assign dec_funct = (state == S_ID) ? order_func : funct_q;

    ctrl_decode u_decode (
        .op         (dec_op),
        .order_func (dec_funct),
        .dec        (dec),
        .legal      (legal)
    );

    assign mem_expired = (wait_cnt == CW'(MEM_WAIT_MAX));
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IF;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_ID) begin
                op_q    <= op;
                funct_q <= order_func;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_MEM && !mem_ready && !mem_expired)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (state == S_ID && !legal)
                illegal_q <= 1'b1;
            if (state == S_MEM && !mem_ready && mem_expired)
                timeout_q <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                if (!legal)
                    next_state = S_HALT;
                else if (dec.cls == CL_J || dec.cls == CL_JAL)
                    next_state = S_IF;
                else
                    next_state = S_EX;
            end
            S_EX: begin
                case (dec.cls)
                    CL_BEQ, CL_JR: next_state = S_IF;
                    CL_LW, CL_SW:  next_state = S_MEM;
                    default:       next_state = S_WB;
                endcase
            end
            // Ready on the final permitted wait cycle still completes the access.
            S_MEM: begin
                if (mem_ready)
                    next_state = (dec.cls == CL_SW) ? S_IF : S_WB;
                else if (mem_expired)
                    next_state = S_HALT;
            end
            S_WB:    next_state = S_IF;
            default: next_state = S_HALT;
        endcase
    end

    always_comb begin
        PC_write   = 1'b0;
        IR_write   = 1'b0;
        pc_src     = PC_SEQ;
        GPR_write  = 1'b0;
        rd         = 1'b0;
        jal        = 1'b0;
        imm_to_ALU = 1'b0;
        Extop      = 1'b0;
        lui        = 1'b0;
        sel_ALU    = ALU_ADD;
        RAM_write  = 1'b0;
        RAM_read   = 1'b0;
        RAM_to_GPR = 1'b0;
        instr_done = 1'b0;
        // Gating on rst_n keeps the IF strobes quiet while reset holds state at IF.
        if (rst_n) begin
            if (state == S_EX || state == S_MEM || state == S_WB) begin
                sel_ALU    = dec.sel_alu;
                imm_to_ALU = dec.imm_to_alu;
                Extop      = dec.extop;
            end
            case (state)
                S_IF: begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    pc_src   = PC_SEQ;
                end
                S_ID: begin
                    if (dec.cls == CL_J || dec.cls == CL_JAL) begin
                        PC_write   = 1'b1;
                        pc_src     = PC_JUMP;
                        instr_done = 1'b1;
                        GPR_write  = (dec.cls == CL_JAL);
                        jal        = (dec.cls == CL_JAL);
                    end
                end
                S_EX: begin
                    if (dec.cls == CL_BEQ) begin
                        pc_src     = PC_BRANCH;
                        PC_write   = zero;
                        instr_done = 1'b1;
                    end else if (dec.cls == CL_JR) begin
                        pc_src     = PC_REG;
                        PC_write   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    RAM_read   = (dec.cls == CL_LW);
                    RAM_write  = (dec.cls == CL_SW);
                    instr_done = (dec.cls == CL_SW) && mem_ready;
                end
                S_WB: begin
                    GPR_write  = 1'b1;
                    instr_done = 1'b1;
                    rd         = dec.rd;
                    lui        = dec.lui;
                    RAM_to_GPR = (dec.cls == CL_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle compares the full output vector
// against a hand-written expected vector.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] order_func;
    logic       zero;
    logic       mem_ready;
    logic       PC_write, IR_write, GPR_write, rd, jal, imm_to_ALU, Extop, lui;
    logic [1:0] pc_src;
    logic [3:0] sel_ALU;
    logic       RAM_write, RAM_read, RAM_to_GPR, instr_done, illegal, mem_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .order_func (order_func),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .PC_write   (PC_write),
        .IR_write   (IR_write),
        .pc_src     (pc_src),
        .GPR_write  (GPR_write),
        .rd         (rd),
        .jal        (jal),
        .imm_to_ALU (imm_to_ALU),
        .Extop      (Extop),
        .lui        (lui),
        .sel_ALU    (sel_ALU),
        .RAM_write  (RAM_write),
        .RAM_read   (RAM_read),
        .RAM_to_GPR (RAM_to_GPR),
        .instr_done (instr_done),
        .illegal    (illegal),
        .mem_timeout(mem_timeout)
    );

    // {PC_write, IR_write, pc_src, GPR_write, rd, jal, imm, Extop, lui, sel_ALU,
    //  RAM_write, RAM_read, RAM_to_GPR, instr_done, illegal, mem_timeout}
    logic [19:0] obs;
    assign obs = {PC_write, IR_write, pc_src, GPR_write, rd, jal, imm_to_ALU, Extop, lui,
                  sel_ALU, RAM_write, RAM_read, RAM_to_GPR, instr_done, illegal, mem_timeout};

    function automatic logic [19:0] ov(
        input logic pcw, input logic irw, input logic [1:0] pcs,
        input logic gw, input logic rdd, input logic jl, input logic imm,
        input logic ext, input logic lu, input logic [3:0] alu,
        input logic rw, input logic rr, input logic r2g, input logic dn,
        input logic ill, input logic to);
        return {pcw, irw, pcs, gw, rdd, jl, imm, ext, lu, alu, rw, rr, r2g, dn, ill, to};
    endfunction

    // Called just after a rising edge with this cycle's inputs applied.
    task automatic step(input string tag, input logic [19:0] exp);
        #1;
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [19:0] V_ZERO = 20'h0;

    logic [5:0] r_funct [5];
    logic [3:0] r_alu   [5];
    logic [19:0] v_if, v_lw_ex, v_lw_mem, v_lw_wb, v_sw_wait, v_sw_done;

    initial begin
        r_funct = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
        r_alu   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        v_if      = ov(1,1,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,0,0);
        v_lw_ex   = ov(0,0,2'd0, 0,0,0,1,1,0, 4'd0, 0,0,0,0,0,0);
        v_lw_mem  = ov(0,0,2'd0, 0,0,0,1,1,0, 4'd0, 0,1,0,0,0,0);
        v_lw_wb   = ov(0,0,2'd0, 1,0,0,1,1,0, 4'd0, 0,0,1,1,0,0);
        v_sw_wait = ov(0,0,2'd0, 0,0,0,1,1,0, 4'd0, 1,0,0,0,0,0);
        v_sw_done = ov(0,0,2'd0, 0,0,0,1,1,0, 4'd0, 1,0,0,1,0,0);

        rst_n = 1'b0; op = 6'h00; order_func = 6'h21; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold", V_ZERO);
        rst_n = 1'b1;

        // R-type ALU ops: 4 cycles, rd=1 in WB
        for (int i = 0; i < 5; i++) begin
            op = 6'h00; order_func = r_funct[i];
            step("rt_if", v_if);
            step("rt_id", V_ZERO);
            step("rt_ex", ov(0,0,2'd0, 0,0,0,0,0,0, r_alu[i], 0,0,0,0,0,0));
            step("rt_wb", ov(0,0,2'd0, 1,1,0,0,0,0, r_alu[i], 0,0,0,1,0,0));
        end

        // beq taken and not taken, then jr
        op = 6'h04; zero = 1'b1;
        step("beq1_if", v_if);
        step("beq1_id", V_ZERO);
        step("beq1_ex", ov(1,0,2'd1, 0,0,0,0,1,0, 4'd1, 0,0,0,1,0,0));
        zero = 1'b0;
        step("beq0_if", v_if);
        step("beq0_id", V_ZERO);
        step("beq0_ex", ov(0,0,2'd1, 0,0,0,0,1,0, 4'd1, 0,0,0,1,0,0));
        op = 6'h00; order_func = 6'h08;
        step("jr_if", v_if);
        step("jr_id", V_ZERO);
        step("jr_ex", ov(1,0,2'd3, 0,0,0,0,0,0, 4'd0, 0,0,0,1,0,0));

        // j and jal finish in ID
        op = 6'h02;
        step("j_if", v_if);
        step("j_id", ov(1,0,2'd2, 0,0,0,0,0,0, 4'd0, 0,0,0,1,0,0));
        op = 6'h03;
        step("jal_if", v_if);
        step("jal_id", ov(1,0,2'd2, 1,0,1,0,0,0, 4'd0, 0,0,0,1,0,0));

        // immediate forms
        op = 6'h09;
        step("addiu_if", v_if);
        step("addiu_id", V_ZERO);
        step("addiu_ex", ov(0,0,2'd0, 0,0,0,1,1,0, 4'd0, 0,0,0,0,0,0));
        step("addiu_wb", ov(0,0,2'd0, 1,0,0,1,1,0, 4'd0, 0,0,0,1,0,0));
        op = 6'h0D;
        step("ori_if", v_if);
        step("ori_id", V_ZERO);
        step("ori_ex", ov(0,0,2'd0, 0,0,0,1,0,0, 4'd3, 0,0,0,0,0,0));
        step("ori_wb", ov(0,0,2'd0, 1,0,0,1,0,0, 4'd3, 0,0,0,1,0,0));
        op = 6'h0F;
        step("lui_if", v_if);
        step("lui_id", V_ZERO);
        step("lui_ex", ov(0,0,2'd0, 0,0,0,1,0,0, 4'd0, 0,0,0,0,0,0));
        step("lui_wb", ov(0,0,2'd0, 1,0,0,1,0,1, 4'd0, 0,0,0,1,0,0));

        // lw with 3 wait cycles; mem_ready high before MEM must be ignored
        op = 6'h23;
        step("lw3_if", v_if);
        mem_ready = 1'b1;
        step("lw3_id", V_ZERO);
        step("lw3_ex", v_lw_ex);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw3_mem_wait", v_lw_mem);
        mem_ready = 1'b1;
        step("lw3_mem_ready", v_lw_mem);
        mem_ready = 1'b0;
        step("lw3_wb", v_lw_wb);

        // sw completing immediately
        op = 6'h2B;
        step("sw0_if", v_if);
        step("sw0_id", V_ZERO);
        step("sw0_ex", v_lw_ex);
        mem_ready = 1'b1;
        step("sw0_mem", v_sw_done);
        mem_ready = 1'b0;

        // lw with ready on the last allowed cycle: success, no timeout
        op = 6'h23;
        step("lw15_if", v_if);
        step("lw15_id", V_ZERO);
        step("lw15_ex", v_lw_ex);
        for (int i = 0; i < 15; i++) step("lw15_mem_wait", v_lw_mem);
        mem_ready = 1'b1;
        step("lw15_mem_ready", v_lw_mem);
        mem_ready = 1'b0;
        step("lw15_wb", v_lw_wb);

        // reset mid-lw, held 3 cycles
        step("rst_lw_if", v_if);
        step("rst_lw_id", V_ZERO);
        step("rst_lw_ex", v_lw_ex);
        step("rst_lw_mem", v_lw_mem);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_lw_hold", V_ZERO);
        op = 6'h2B;
        rst_n = 1'b1;

        // sw timeout: 16 request cycles, then HALT with mem_timeout
        step("swto_if", v_if);
        step("swto_id", V_ZERO);
        step("swto_ex", v_lw_ex);
        for (int i = 0; i < 16; i++) step("swto_mem_wait", v_sw_wait);
        step("swto_halt", ov(0,0,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,0,1));
        mem_ready = 1'b1; op = 6'h02;
        step("swto_halt_hold", ov(0,0,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,0,1));
        mem_ready = 1'b0;
        rst_n = 1'b0;
        step("swto_reset", V_ZERO);
        op = 6'h3F;
        rst_n = 1'b1;

        // illegal opcode
        step("ill_op_if", v_if);
        step("ill_op_id", V_ZERO);
        step("ill_op_halt", ov(0,0,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,1,0));
        op = 6'h02;
        step("ill_op_hold", ov(0,0,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,1,0));
        rst_n = 1'b0;
        step("ill_reset", V_ZERO);
        op = 6'h00; order_func = 6'h3F;
        rst_n = 1'b1;

        // illegal funct
        step("ill_fn_if", v_if);
        step("ill_fn_id", V_ZERO);
        step("ill_fn_halt", ov(0,0,2'd0, 0,0,0,0,0,0, 4'd0, 0,0,0,0,1,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
